// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: data width, opcodes,
// FSM state encoding, the queued command record and the divide-by-zero test.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int CMD_W  = 2 + 2 * DATA_W;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WAIT = 2'b10
  } state_e;

  // One queued command, packed as {op, a, b}
  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_t;

  // True when the operation is a divide with a zero divisor; the ALU result
  // is not trusted in that case and a defined value is substituted.
  function automatic logic is_div_by_zero(input logic [1:0] op,
                                          input logic [DATA_W-1:0] b);
    return (op == OP_DIV) && (b == {DATA_W{1'b0}});
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO holding {op, a, b} records. Push is refused when
// full (even if a pop happens in the same cycle); pop is ignored when empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  logic           pop_i,
  input  cmd_t           wdata_i,
  output cmd_t           rdata_o,
  output logic [PTR_W:0] count_o,
  output logic           full_o,
  output logic           empty_o
);

  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d;
  logic [PTR_W:0]   count_q;
  logic [PTR_W:0]   count_d;
  logic             do_push_s;
  logic             do_pop_s;
  logic             full_s;
  logic             empty_s;

  assign full_s    = (count_q == (PTR_W + 1)'(DEPTH));
  assign empty_s   = (count_q == {(PTR_W + 1){1'b0}});
  assign do_push_s = push_i && !full_s;
  assign do_pop_s  = pop_i && !empty_s;

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_s;
  assign empty_o = empty_s;

  // Next pointer and occupancy; pointers wrap naturally at a power-of-two depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer, count and storage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {(PTR_W + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {CMD_W{1'b0}};
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage in front of a combinational ALU: queues commands, drives
// registered operands to the ALU, captures the result when the ALU signals
// ready and holds it under a valid/ready handshake. Divide-by-zero results
// are replaced by zero with a flag so an undefined ALU value never escapes.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [1:0]        cmd_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [1:0]        rsp_op,
  output logic              rsp_div0,
  output logic              busy
);

  state_e            state_q;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [1:0]        alu_opcode_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic [1:0]        rsp_op_q;
  logic              rsp_div0_q;

  cmd_t              wr_cmd_s;
  cmd_t              head_s;
  logic [PTR_W:0]    fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              push_s;
  logic              pop_s;
  logic              div0_s;
  logic [DATA_W-1:0] cap_result_s;

  assign wr_cmd_s  = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign cmd_ready = !fifo_full_s;
  assign push_s    = cmd_valid && !fifo_full_s;

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (wr_cmd_s),
    .rdata_o (head_s),
    .count_o (fifo_count_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Pop the FIFO head when idle, or when the held response is being accepted
  always_comb begin
    pop_s = 1'b0;
    case (state_q)
      IDLE:    pop_s = !fifo_empty_s;
      WAIT:    pop_s = rsp_ready && !fifo_empty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Value to capture: the ALU result, or zero when dividing by zero
  always_comb begin
    div0_s = is_div_by_zero(alu_opcode_q, alu_b_q);
    if (div0_s) begin
      cap_result_s = {DATA_W{1'b0}};
    end else begin
      cap_result_s = alu_result;
    end
  end

  // Issue/capture FSM with registered ALU operands and response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_a_q      <= {DATA_W{1'b0}};
      alu_b_q      <= {DATA_W{1'b0}};
      alu_opcode_q <= 2'b00;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= {DATA_W{1'b0}};
      rsp_op_q     <= 2'b00;
      rsp_div0_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop_s) begin
            alu_a_q      <= head_s.a;
            alu_b_q      <= head_s.b;
            alu_opcode_q <= head_s.op;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          if (alu_ready) begin
            rsp_result_q <= cap_result_s;
            rsp_op_q     <= alu_opcode_q;
            rsp_div0_q   <= div0_s;
            rsp_valid_q  <= 1'b1;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (pop_s) begin
              alu_a_q      <= head_s.a;
              alu_b_q      <= head_s.b;
              alu_opcode_q <= head_s.op;
              state_q      <= EXEC;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_div0   = rsp_div0_q;
  assign busy       = (fifo_count_s != {(PTR_W + 1){1'b0}}) || (state_q != IDLE);

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed, table-driven bench for alu_issue_stage with a behavioural ALU.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [1:0]  cmd_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [1:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        alu_ready;
  logic        alu_rdy;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_op;
  logic        rsp_div0;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] res;
    logic        div0;
  } vec_t;

  vec_t vecs1[8];
  vec_t vecs2[8];

  alu_issue_stage dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_ready  (alu_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_div0   (rsp_div0),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU; a divide by zero yields garbage that must never be forwarded
  always_comb begin
    case (alu_opcode)
      2'b00:   alu_result = alu_a + alu_b;
      2'b01:   alu_result = alu_a - alu_b;
      2'b10:   alu_result = alu_a * alu_b;
      default: alu_result = (alu_b == 32'd0) ? 32'hDEAD_BEEF : alu_a / alu_b;
    endcase
  end
  assign alu_ready = alu_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Offer a command at a negedge and hold it until accepted (bounded)
  task automatic push_wait(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    bit acc = 1'b0;
    int n = 0;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    while (n < 50) begin
      acc = cmd_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) break;
      n++;
    end
    cmd_valid = 1'b0;
    if (!acc) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrive", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_clear", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs1[0] = '{32'd100, 32'd0, 2'b11, 32'd0, 1'b1};
    vecs1[1] = '{32'd100, 32'd7, 2'b11, 32'd14, 1'b0};
    vecs1[2] = '{32'd10, 32'd3, 2'b01, 32'd7, 1'b0};
    vecs1[3] = '{32'd6, 32'd7, 2'b10, 32'd42, 1'b0};
    vecs1[4] = '{32'hFFFF_FFFF, 32'd1, 2'b00, 32'd0, 1'b0};
    vecs1[5] = '{32'd0, 32'd1, 2'b01, 32'hFFFF_FFFF, 1'b0};
    vecs1[6] = '{32'h0001_0000, 32'h0001_0000, 2'b10, 32'd0, 1'b0};
    vecs1[7] = '{32'd7, 32'd100, 2'b11, 32'd0, 1'b0};

    vecs2[0] = '{32'd10, 32'd3, 2'b01, 32'd7, 1'b0};
    vecs2[1] = '{32'd6, 32'd7, 2'b10, 32'd42, 1'b0};
    vecs2[2] = '{32'd1, 32'd2, 2'b00, 32'd3, 1'b0};
    vecs2[3] = '{32'd100, 32'd4, 2'b11, 32'd25, 1'b0};
    vecs2[4] = '{32'd5, 32'd0, 2'b11, 32'd0, 1'b1};
    vecs2[5] = '{32'hFFFF_FFFF, 32'd2, 2'b10, 32'hFFFF_FFFE, 1'b0};
    vecs2[6] = '{32'd3, 32'd10, 2'b01, 32'hFFFF_FFF9, 1'b0};
    vecs2[7] = '{32'h7FFF_FFFF, 32'd1, 2'b00, 32'h8000_0000, 1'b0};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = 32'd0;
    cmd_b = 32'd0;
    cmd_op = 2'b00;
    rsp_ready = 1'b0;
    alu_rdy = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    rst = 1'b0;

    // Single add with latency: accept at edge N, rsp_valid after N+2
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_a = 32'd5;
    cmd_b = 32'd7;
    cmd_op = 2'b00;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("lat_n0_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("lat_n0_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("lat_n1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("lat_n1_alu_a", alu_a, 32'd5);
    chk("lat_n1_alu_b", alu_b, 32'd7);
    @(negedge clk);
    chk("lat_n2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("add_result", rsp_result, 32'd12);
    chk("add_op", {30'd0, rsp_op}, 32'd0);
    chk("add_div0", {31'd0, rsp_div0}, 32'd0);
    take();

    // Table of single operations
    for (int i = 0; i < 8; i++) begin
      push_wait(vecs1[i].a, vecs1[i].b, vecs1[i].op);
      wait_rsp();
      chk($sformatf("vec%0d_result", i), rsp_result, vecs1[i].res);
      chk($sformatf("vec%0d_op", i), {30'd0, rsp_op}, {30'd0, vecs1[i].op});
      chk($sformatf("vec%0d_div0", i), {31'd0, rsp_div0}, {31'd0, vecs1[i].div0});
      take();
    end

    // Backpressure: fill FIFO behind a held response, then drain in order
    begin
      bit acc[6];
      int k = 0;
      for (int c = 0; c < 40; c++) begin
        if (c < 6) begin
          cmd_valid = 1'b1;
          cmd_a = 32'(c * 10);
          cmd_b = 32'(c);
          cmd_op = 2'b00;
          acc[c] = cmd_ready;
          if (c == 5) rsp_ready = 1'b1;
        end else begin
          cmd_valid = 1'b0;
        end
        if (rsp_valid && rsp_ready) begin
          if (k < 5) chk($sformatf("bp_rsp%0d", k), rsp_result, 32'(k * 11));
          k++;
        end
        @(posedge clk);
        @(negedge clk);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      chk("bp_acc3", {31'd0, acc[3]}, 32'd1);
      chk("bp_acc4", {31'd0, acc[4]}, 32'd1);
      chk("bp_full_refuse", {31'd0, acc[5]}, 32'd0);
      chk("bp_rsp_count", 32'(k), 32'd5);
      chk("bp_busy_end", {31'd0, busy}, 32'd0);
    end

    // ALU stall: operands held, no response until alu_ready
    alu_rdy = 1'b0;
    push_wait(32'd10, 32'd3, 2'b01);
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      chk("stall_alu_a", alu_a, 32'd10);
      chk("stall_alu_b", alu_b, 32'd3);
      chk("stall_alu_op", {30'd0, alu_opcode}, 32'd1);
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    alu_rdy = 1'b1;
    @(negedge clk);
    chk("stall_rsp_valid_after", {31'd0, rsp_valid}, 32'd1);
    chk("stall_result", rsp_result, 32'd7);
    take();
    chk("stall_single_capture", {31'd0, busy}, 32'd0);

    // Back-to-back stream with rsp_ready held high
    rsp_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          push_wait(vecs2[i].a, vecs2[i].b, vecs2[i].op);
        end
      end
      begin
        int k = 0;
        int last = 0;
        int n = 0;
        while (k < 8 && n < 100) begin
          @(negedge clk);
          n++;
          if (rsp_valid) begin
            chk($sformatf("b2b%0d_result", k), rsp_result, vecs2[k].res);
            chk($sformatf("b2b%0d_div0", k), {31'd0, rsp_div0}, {31'd0, vecs2[k].div0});
            if (k > 0) chk($sformatf("b2b%0d_gap", k), 32'(cyc - last), 32'd2);
            last = cyc;
            k++;
          end
        end
        chk("b2b_count", 32'(k), 32'd8);
      end
    join
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("b2b_idle", {31'd0, busy}, 32'd0);

    // Mid-operation reset with commands queued
    alu_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_wait(32'(i + 1), 32'd1, 2'b00);
    end
    @(negedge clk);
    chk("pre_rst_alu_a", alu_a, 32'd1);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_alu_a", alu_a, 32'd0);
    chk("mrst_alu_b", alu_b, 32'd0);
    chk("mrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    alu_rdy = 1'b1;
    push_wait(32'd20, 32'd22, 2'b00);
    wait_rsp();
    chk("post_rst_result", rsp_result, 32'd42);
    take();
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
